// File: rtl/dual_port_mem_arbiter_pkg.sv
// Shared types and the hazard rule for the dual-port RAM arbiter.
package dual_port_mem_arb_pkg;

    localparam int REQ_COUNT = 4;
    localparam int ADDR_BITS = 4;
    localparam int DATA_BITS = 8;
    localparam int ID_BITS   = $clog2(REQ_COUNT);

    typedef logic [ID_BITS-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } port_tag_t;

    // Port A write + port B read to one address is safe: the RAM forwards A's write data to B.
    function automatic logic addr_conflict(input logic                 we_a,
                                           input logic                 we_b,
                                           input logic [ADDR_BITS-1:0] addr_a,
                                           input logic [ADDR_BITS-1:0] addr_b);
        return (addr_a == addr_b) && (we_a || we_b) && !(we_a && !we_b);
    endfunction

endpackage

// File: rtl/dual_port_mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the start index, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(start) + off) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// Shares both ports of a dual-port RAM among NREQ requesters; reads return two cycles after grant.
module dual_port_mem_arbiter
    import dual_port_mem_arb_pkg::*;
#(
    parameter int NREQ  = REQ_COUNT,
    parameter int ABITS = ADDR_BITS,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*ABITS-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NREQ*WIDTH-1:0] rsp_data,
    output logic                  mem_wren_a,
    output logic                  mem_rden_a,
    output logic [ABITS-1:0]      mem_addr_a,
    output logic [WIDTH-1:0]      mem_wdata_a,
    input  logic [WIDTH-1:0]      mem_rdata_a,
    output logic                  mem_wren_b,
    output logic                  mem_rden_b,
    output logic [ABITS-1:0]      mem_addr_b,
    output logic [WIDTH-1:0]      mem_wdata_b,
    input  logic [WIDTH-1:0]      mem_rdata_b
);

    logic [NREQ-1:0][ABITS-1:0] addr_v;
    logic [NREQ-1:0][WIDTH-1:0] wdata_v;
    logic [NREQ-1:0]            valid_eff;
    logic [NREQ-1:0]            cand_b;
    logic [NREQ-1:0]            grant_a;
    logic [NREQ-1:0]            grant_b;
    logic                       found_a;
    logic                       found_b;
    req_id_t                    idx_a;
    req_id_t                    idx_b;
    req_id_t                    ptr_q;
    req_id_t                    ptr_d;
    port_tag_t                  tag_a_q;
    port_tag_t                  tag_a_d;
    port_tag_t                  tag_b_q;
    port_tag_t                  tag_b_d;
    logic [NREQ-1:0]            rsp_valid_q;
    logic [NREQ-1:0]            rsp_valid_d;
    logic [NREQ-1:0][WIDTH-1:0] rsp_data_q;
    logic [NREQ-1:0][WIDTH-1:0] rsp_data_d;

    function automatic req_id_t wrap_inc(input req_id_t i);
        return (int'(i) == NREQ - 1) ? '0 : req_id_t'(i + 1'b1);
    endfunction

    assign addr_v    = req_addr;
    assign wdata_v   = req_wdata;
    // Masking the requests during reset keeps every grant and RAM enable low.
    assign valid_eff = rst ? '0 : req_valid;

    rr_pick #(.N(NREQ), .IW(ID_BITS)) u_pick_a (
        .req   (valid_eff),
        .start (ptr_q),
        .grant (grant_a),
        .idx   (idx_a),
        .found (found_a)
    );

    always_comb begin
        cand_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_b[i] = valid_eff[i] && !grant_a[i] &&
                        !addr_conflict(req_we[idx_a], req_we[i], addr_v[idx_a], addr_v[i]);
        end
    end

    rr_pick #(.N(NREQ), .IW(ID_BITS)) u_pick_b (
        .req   (cand_b),
        .start (ptr_q),
        .grant (grant_b),
        .idx   (idx_b),
        .found (found_b)
    );

    assign req_ready = grant_a | grant_b;

    always_comb begin
        mem_wren_a  = found_a && req_we[idx_a];
        mem_rden_a  = found_a && !req_we[idx_a];
        mem_addr_a  = found_a ? addr_v[idx_a] : '0;
        mem_wdata_a = found_a ? wdata_v[idx_a] : '0;
        mem_wren_b  = found_b && req_we[idx_b];
        mem_rden_b  = found_b && !req_we[idx_b];
        mem_addr_b  = found_b ? addr_v[idx_b] : '0;
        mem_wdata_b = found_b ? wdata_v[idx_b] : '0;
        tag_a_d.vld = mem_rden_a;
        tag_a_d.id  = idx_a;
        tag_b_d.vld = mem_rden_b;
        tag_b_d.id  = idx_b;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found_b) begin
            ptr_d = wrap_inc(idx_b);
        end else if (found_a) begin
            ptr_d = wrap_inc(idx_a);
        end
    end

    // Tags issued last cycle line up with the RAM output now; register it as the response.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_a_q.vld) begin
            rsp_valid_d[tag_a_q.id] = 1'b1;
            rsp_data_d[tag_a_q.id]  = mem_rdata_a;
        end
        if (tag_b_q.vld) begin
            rsp_valid_d[tag_b_q.id] = 1'b1;
            rsp_data_d[tag_b_q.id]  = mem_rdata_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            tag_a_q     <= '0;
            tag_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_a_q     <= tag_a_d;
            tag_b_q     <= tag_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Scoreboard bench for dual_port_mem_arbiter with a behavioural write-forwarding dual-port RAM.
module tb_dual_port_mem_arbiter;

    localparam int NREQ  = 4;
    localparam int ABITS = 4;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*ABITS-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ*WIDTH-1:0] rsp_data;
    logic                  mem_wren_a;
    logic                  mem_rden_a;
    logic [ABITS-1:0]      mem_addr_a;
    logic [WIDTH-1:0]      mem_wdata_a;
    logic [WIDTH-1:0]      mem_rdata_a;
    logic                  mem_wren_b;
    logic                  mem_rden_b;
    logic [ABITS-1:0]      mem_addr_b;
    logic [WIDTH-1:0]      mem_wdata_b;
    logic [WIDTH-1:0]      mem_rdata_b;

    logic [WIDTH-1:0] ram    [16];
    logic [WIDTH-1:0] shadow [16];
    exp_t             sb_q   [NREQ][$];
    int               cycle = 0;
    int               checks = 0;
    int               passes = 0;
    int               pulses_r2 = 0;

    always #5 clk = ~clk;

    dual_port_mem_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_wren_a  (mem_wren_a),
        .mem_rden_a  (mem_rden_a),
        .mem_addr_a  (mem_addr_a),
        .mem_wdata_a (mem_wdata_a),
        .mem_rdata_a (mem_rdata_a),
        .mem_wren_b  (mem_wren_b),
        .mem_rden_b  (mem_rden_b),
        .mem_addr_b  (mem_addr_b),
        .mem_wdata_b (mem_wdata_b),
        .mem_rdata_b (mem_rdata_b)
    );

    // Write-priority RAM: a read on one port sees the other port's same-cycle write data.
    always @(posedge clk) begin
        if (mem_rden_a) mem_rdata_a <= (mem_wren_b && mem_addr_b == mem_addr_a) ? mem_wdata_b : ram[mem_addr_a];
        if (mem_rden_b) mem_rdata_b <= (mem_wren_a && mem_addr_a == mem_addr_b) ? mem_wdata_a : ram[mem_addr_b];
        if (mem_wren_a) ram[mem_addr_a] <= mem_wdata_a;
        if (mem_wren_b) ram[mem_addr_b] <= mem_wdata_b;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int id, input logic vld, input logic we,
                                 input logic [ABITS-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[id]                   = vld;
        req_we[id]                      = we;
        req_addr[id*ABITS +: ABITS]     = a;
        req_wdata[id*WIDTH +: WIDTH]    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearAll();
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 1'b0, '0, '0);
    endtask

    // Responses are matched against expectations recorded when each read was granted.
    always @(negedge clk) begin : monitor
        exp_t             e;
        logic [ABITS-1:0] ai;
        if (rst) begin
            for (int i = 0; i < NREQ; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    if (i == 2) pulses_r2++;
                    if (sb_q[i].size() == 0) begin
                        checkOutput("rsp_unexpected", 32'(rsp_valid[i]), 32'd0);
                    end else begin
                        e = sb_q[i].pop_front();
                        checkOutput("rsp_data", 32'(rsp_data[i*WIDTH +: WIDTH]), 32'(e.data));
                        checkOutput("rsp_cycle", cycle, e.due);
                    end
                end else if (sb_q[i].size() > 0 && sb_q[i][0].due < cycle) begin
                    checkOutput("rsp_missing", 32'(rsp_valid[i]), 32'd1);
                    e = sb_q[i].pop_front();
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && !req_valid[i]) checkOutput("ready_without_valid", 32'(req_ready[i]), 32'd0);
                if (req_ready[i] && !req_we[i]) begin
                    ai     = req_addr[i*ABITS +: ABITS];
                    e.data = shadow[ai];
                    for (int j = 0; j < NREQ; j++) begin
                        if (req_ready[j] && req_we[j] && req_addr[j*ABITS +: ABITS] == ai)
                            e.data = req_wdata[j*WIDTH +: WIDTH];
                    end
                    e.due = cycle + 2;
                    sb_q[i].push_back(e);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && req_we[i])
                    shadow[req_addr[i*ABITS +: ABITS]] = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants [NREQ];
        int start_pulses;
        for (int i = 0; i < 16; i++) begin
            ram[i]    = WIDTH'(i * 37 + 5);
            shadow[i] = WIDTH'(i * 37 + 5);
        end
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;

        // Reset with every requester asking
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b0, ABITS'(i), '0);
        tick();
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", 32'(req_ready), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("rst_enables", 32'({mem_wren_a, mem_rden_a, mem_wren_b, mem_rden_b}), 32'd0);
            tick();
        end
        rst = 1'b0;
        clearAll();
        @(negedge clk);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        tick();

        // Write then read, requester 0
        applyStimulus(0, 1'b1, 1'b1, 4'd3, 8'h5A);
        @(negedge clk);
        checkOutput("wr_ready", 32'(req_ready), 32'b0001);
        checkOutput("wr_wren_a", 32'(mem_wren_a), 32'd1);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        checkOutput("rd_ready", 32'(req_ready), 32'b0001);
        checkOutput("rd_rden_a", 32'(mem_rden_a), 32'd1);
        tick();
        clearAll();
        @(negedge clk);
        checkOutput("rd_t1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("rd_t2_rsp_valid", 32'(rsp_valid), 32'b0001);
        checkOutput("rd_t2_rsp_data", 32'(rsp_data[7:0]), 32'h5A);
        tick();

        // Round-robin fairness from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 1'b1, 1'b0, ABITS'(8 + i), '0);
            grants[i] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("rr_pair", 32'(req_ready), (c % 2 == 0) ? 32'b0011 : 32'b1100);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[i]++;
            tick();
        end
        clearAll();
        for (int i = 0; i < NREQ; i++) checkOutput("rr_share", grants[i], 4);
        repeat (4) tick();

        // Write A + read B on address 7 proceed together, read sees new data
        applyStimulus(0, 1'b1, 1'b1, 4'd7, 8'hC3);
        applyStimulus(1, 1'b1, 1'b0, 4'd7, 8'h00);
        @(negedge clk);
        checkOutput("wr_rd_ready", 32'(req_ready), 32'b0011);
        checkOutput("wr_rd_ports", 32'({mem_wren_a, mem_rden_b}), 32'b11);
        tick();
        clearAll();
        tick();
        @(negedge clk);
        checkOutput("wr_rd_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        checkOutput("wr_rd_rsp_data", 32'(rsp_data[15:8]), 32'hC3);
        tick();

        // Read A + write B on one address serialise
        applyStimulus(0, 1'b1, 1'b0, 4'd7, 8'h00);
        applyStimulus(1, 1'b1, 1'b1, 4'd7, 8'h11);
        @(negedge clk);
        checkOutput("rd_wr_first", 32'(req_ready), 32'b0001);
        tick();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("rd_wr_second", 32'(req_ready), 32'b0010);
        tick();
        clearAll();

        // Write + write serialise; the later grant wins
        applyStimulus(0, 1'b1, 1'b1, 4'd7, 8'h22);
        applyStimulus(1, 1'b1, 1'b1, 4'd7, 8'h33);
        @(negedge clk);
        checkOutput("wr_wr_first", 32'(req_ready), 32'b0001);
        tick();
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("wr_wr_second", 32'(req_ready), 32'b0010);
        tick();
        clearAll();
        @(negedge clk);
        checkOutput("wr_wr_final", 32'(ram[7]), 32'h33);
        tick();
        applyStimulus(3, 1'b1, 1'b0, 4'd7, 8'h00);
        tick();
        clearAll();
        repeat (4) tick();

        // Reset the cycle after a read grant drops the response
        applyStimulus(2, 1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        checkOutput("midrst_ready", 32'(req_ready), 32'b0100);
        tick();
        clearAll();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rsp_t1", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end

        // Requester 2 streams reads over the whole RAM
        start_pulses = pulses_r2;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2, 1'b1, 1'b0, ABITS'(k), 8'h00);
            @(negedge clk);
            checkOutput("stream_ready", 32'(req_ready), 32'b0100);
            tick();
        end
        clearAll();
        repeat (4) tick();
        checkOutput("stream_pulses", pulses_r2 - start_pulses, 16);

        for (int i = 0; i < NREQ; i++) checkOutput("sb_drained", sb_q[i].size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
